operand_fetch: RTL and testbench

Pipeline stage between instruction decode and execute. It drives the register file read-address ports and captures both operands into a registered output. An 8-entry pending-write scoreboard blocks read-after-write and write-after-write hazards, and an optional bypass forwards the write-back value in the same cycle it is written. A valid/ready handshake is used on both sides, and the stage holds completely while `clk_en` is low.

---
 rtl/opfetch_pkg.sv | 14 +
 rtl/operand_fetch_scoreboard.sv | 29 ++
 rtl/operand_fetch.sv | 101 ++++++++++
 tb/tb_operand_fetch.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared widths and the decoded-issue record for operand_fetch.
package opfetch_pkg;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 8;
  localparam int REG_W = $clog2(NUM_REGS);
  typedef struct packed {
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [REG_W-1:0]  dst;
    logic              wb;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } issue_t;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// reg_scoreboard: pending-write bits with set-over-clear priority and three index queries.
module reg_scoreboard
  import opfetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set,
  input  logic [REG_W-1:0] i_set_idx,
  input  logic             i_clr,
  input  logic [REG_W-1:0] i_clr_idx,
  input  logic [REG_W-1:0] i_q1_idx,
  input  logic [REG_W-1:0] i_q2_idx,
  input  logic [REG_W-1:0] i_q3_idx,
  output logic             o_q1,
  output logic             o_q2,
  output logic             o_q3
);
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  assign w_set = i_set ? NUM_REGS'(1) << i_set_idx : '0;
  assign w_clr = i_clr ? NUM_REGS'(1) << i_clr_idx : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  assign o_q1 = r_pending[i_q1_idx];
  assign o_q2 = r_pending[i_q2_idx];
  assign o_q3 = r_pending[i_q3_idx];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-file read, RAW/WAW scoreboard stall and operand capture stage.
// Define OPFETCH_WB_BYPASS_EN to forward wb_val to sources written in the same cycle.
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_src1,
  input  logic [REG_W-1:0]  in_src2,
  input  logic [REG_W-1:0]  in_dst,
  input  logic              in_wb,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [REG_W-1:0]  rf_rd1,
  output logic [REG_W-1:0]  rf_rd2,
  input  logic [DATA_W-1:0] rf_q1,
  input  logic [DATA_W-1:0] rf_q2,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_wb
);
  issue_t            w_iss;
  logic              w_pend1, w_pend2, w_pendd;
  logic              w_byp1, w_byp2;
  logic              w_hazard, w_fire;
  logic [DATA_W-1:0] w_a, w_b;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_a, r_out_b;
  logic [REG_W-1:0]  r_out_dst;
  logic              r_out_wb;

  assign w_iss = '{src1: in_src1, src2: in_src2, dst: in_dst, wb: in_wb, use_imm: in_use_imm, imm: in_imm};
  assign rf_rd1 = w_iss.src1;
  assign rf_rd2 = w_iss.src2;

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set     (w_fire && w_iss.wb),
    .i_set_idx (w_iss.dst),
    .i_clr     (wb_en),
    .i_clr_idx (wb_reg),
    .i_q1_idx  (w_iss.src1),
    .i_q2_idx  (w_iss.src2),
    .i_q3_idx  (w_iss.dst),
    .o_q1      (w_pend1),
    .o_q2      (w_pend2),
    .o_q3      (w_pendd)
  );

`ifdef OPFETCH_WB_BYPASS_EN
  assign w_byp1 = wb_en && (wb_reg == w_iss.src1);
  assign w_byp2 = wb_en && (wb_reg == w_iss.src2);
  assign w_a = w_byp1 ? wb_val : rf_q1;
  assign w_b = w_iss.use_imm ? w_iss.imm : (w_byp2 ? wb_val : rf_q2);
`else
  logic w_unused_wb_val;
  assign w_unused_wb_val = ^wb_val;
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
  assign w_a = rf_q1;
  assign w_b = w_iss.use_imm ? w_iss.imm : rf_q2;
`endif

  // A writer retiring this cycle releases the destination even without bypass.
  assign w_hazard = (w_pend1 && !w_byp1)
                 || (!w_iss.use_imm && w_pend2 && !w_byp2)
                 || (w_iss.wb && w_pendd && !(wb_en && wb_reg == w_iss.dst));
  assign in_ready = clk_en && !w_hazard && (!r_out_valid || out_ready);
  assign w_fire = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_dst   <= '0;
      r_out_wb    <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_a;
      r_out_b     <= w_b;
      r_out_dst   <= w_iss.dst;
      r_out_wb    <= w_iss.wb;
    end else if (clk_en && out_ready) r_out_valid <= 1'b0;

  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_dst   = r_out_dst;
  assign out_wb    = r_out_wb;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand_fetch against a small register-file model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, in_valid, in_ready;
  logic [2:0]  in_src1, in_src2, in_dst, rf_rd1, rf_rd2, wb_reg, out_dst;
  logic        in_wb, in_use_imm, wb_en, out_valid, out_ready, out_wb;
  logic [31:0] in_imm, rf_q1, rf_q2, wb_val, out_a, out_b;
  logic [31:0] rf [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_wb(in_wb),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_q1(rf_q1), .rf_q2(rf_q2), .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_dst(out_dst), .out_wb(out_wb)
  );

  assign rf_q1 = rf[rf_rd1];
  assign rf_q2 = rf[rf_rd2];
  always @(posedge clk) if (wb_en) rf[wb_reg] <= wb_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                       input logic w, input logic ui, input logic [31:0] im);
    in_src1 = s1; in_src2 = s2; in_dst = d; in_wb = w; in_use_imm = ui; in_imm = im;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 32'h1111_1111 * i;
    rst_n = 1'b0; clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_reg = '0; wb_val = '0;
    issue(0, 0, 0, 0, 0, 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_a", out_a, 0);
    check("rst_b", out_b, 0);
    check("rst_dst", 32'(out_dst), 0);
    check("rst_wb", 32'(out_wb), 0);
    tick; tick;
    rst_n = 1'b1;
    // independent stream, one per cycle
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(3'(k), 3'(k + 1), 3'(k), 0, 0, 0);
      check("stream_ready", 32'(in_ready), 1);
      check("stream_rd1", 32'(rf_rd1), k);
      check("stream_rd2", 32'(rf_rd2), k + 1);
      tick;
      check("stream_valid", 32'(out_valid), 1);
      check("stream_a", out_a, 32'h1111_1111 * k);
      check("stream_b", out_b, 32'h1111_1111 * (k + 1));
      check("stream_dst", 32'(out_dst), k);
    end
    in_valid = 1'b0;
    tick;
    check("stream_drain", 32'(out_valid), 0);
    // RAW on r3
    in_valid = 1'b1;
    issue(0, 0, 3, 1, 0, 0);
    tick;
    check("i0_valid", 32'(out_valid), 1);
    check("i0_dst", 32'(out_dst), 3);
    check("i0_wb", 32'(out_wb), 1);
    issue(3, 1, 4, 0, 0, 0);
    check("raw_stall0", 32'(in_ready), 0);
    tick;
    check("raw_bubble", 32'(out_valid), 0);
    check("raw_stall1", 32'(in_ready), 0);
    wb_en = 1'b1; wb_reg = 3; wb_val = 32'hDEAD_BEEF;
    #1;
`ifdef OPFETCH_WB_BYPASS_EN
    check("raw_byp_ready", 32'(in_ready), 1);
    tick;
    wb_en = 1'b0;
`else
    check("raw_nobyp_stall", 32'(in_ready), 0);
    tick;
    check("raw_nobyp_bubble", 32'(out_valid), 0);
    wb_en = 1'b0;
    #1;
    check("raw_nobyp_ready", 32'(in_ready), 1);
    tick;
`endif
    check("raw_valid", 32'(out_valid), 1);
    check("raw_a", out_a, 32'hDEAD_BEEF);
    check("raw_b", out_b, 32'h1111_1111);
    check("raw_dst", 32'(out_dst), 4);
    // immediate bypasses a pending src2
    issue(0, 0, 5, 1, 0, 0);
    tick;
    issue(1, 5, 6, 0, 0, 32'h10);
    check("reg_src2_stall", 32'(in_ready), 0);
    issue(1, 5, 6, 0, 1, 32'h10);
    check("imm_ready", 32'(in_ready), 1);
    tick;
    check("imm_a", out_a, 32'h1111_1111);
    check("imm_b", out_b, 32'h10);
    check("imm_wb", 32'(out_wb), 0);
    // backpressure
    out_ready = 1'b0;
    issue(2, 2, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 32'(in_ready), 0);
      tick;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_hold_b", out_b, 32'h10);
      check("bp_hold_dst", 32'(out_dst), 6);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 32'(in_ready), 1);
    tick;
    check("bp_a", out_a, 32'h2222_2222);
    // clk_en low: nothing moves, write-back still clears pending r5
    clk_en = 1'b0;
    issue(1, 1, 1, 0, 0, 0);
    wb_en = 1'b1; wb_reg = 5; wb_val = 32'h55;
    #1;
    check("ce_ready", 32'(in_ready), 0);
    tick;
    check("ce_valid_hold", 32'(out_valid), 1);
    check("ce_a_hold", out_a, 32'h2222_2222);
    wb_en = 1'b0; clk_en = 1'b1;
    issue(0, 5, 7, 0, 0, 0);
    check("ce_pend_cleared", 32'(in_ready), 1);
    tick;
    check("ce_b", out_b, 32'h55);
    check("ce_dst", 32'(out_dst), 7);
    // same-cycle set and clear of r2: set wins
    issue(0, 0, 2, 1, 0, 0);
    tick;
    wb_en = 1'b1; wb_reg = 2; wb_val = 32'h77;
    #1;
    check("waw_release", 32'(in_ready), 1);
    tick;
    wb_en = 1'b0;
    check("sc_dst", 32'(out_dst), 2);
    check("sc_wb", 32'(out_wb), 1);
    in_valid = 1'b0;
    issue(2, 0, 1, 0, 0, 0);
    check("sc_pending2", 32'(in_ready), 0);
    // async reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_a", out_a, 0);
    check("arst_b", out_b, 0);
    check("arst_dst", 32'(out_dst), 0);
    check("arst_wb", 32'(out_wb), 0);
    check("arst_pending", 32'(in_ready), 1);
    tick;
    rst_n = 1'b1;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
